cdc_tx_arbiter: RTL

- Source-domain (clk_a) controller that shares the single 4-bit data/enable synchronizer channel between N_REQ requesters.
- Grants one requester at a time, round-robin. Captures that requester's 4-bit word.
- Drives the synchronizer's data/enable inputs for a fixed hold window, then a fixed quiet gap, so the destination's two-flop enable capture always sees a clean, stable word.
- Sits immediately upstream of the synchronizer, in the clk_a domain.

---
 rtl/cdc_tx_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter sharing one 4-bit data/enable synchronizer channel between
// N_REQ requesters in the clk_a domain, with a fixed hold window and quiet gap.
module cdc_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 3,
  parameter int CNT_W       = 8
) (
  input  logic                 clk_a,
  input  logic                 arstn,
  input  logic                 arb_en,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic [2:0]           grant_id,
  output logic [3:0]           sync_data,
  output logic                 sync_en,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         rr_ptr;
  logic [N_REQ-1:0]   req_rot;
  logic [2:0]         win_off;
  logic [3:0]         ptr_sum;
  logic [2:0]         win_idx;
  logic [2:0]         rr_next;
  logic [3:0]         win_word;
  logic [N_REQ-1:0]   win_onehot;
  logic               grant_fire;

  // Rotate requests so the pointer lands on bit 0; the lowest set bit is the winner offset.
  always_comb begin
    req_rot = N_REQ'({req, req} >> rr_ptr);
    win_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) win_off = 3'(k);
    end
    ptr_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    win_idx = (ptr_sum >= 4'(N_REQ)) ? 3'(ptr_sum - 4'(N_REQ)) : ptr_sum[2:0];
    rr_next = (win_idx == 3'(N_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
  end

  always_comb begin
    win_word   = '0;
    win_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == win_idx) begin
        win_word      = req_data[4*i +: 4];
        win_onehot[i] = 1'b1;
      end
    end
  end

  assign grant_fire = (state == IDLE) && arb_en && (|req);

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_fire)  state_next = HOLD;
      HOLD:    if (cnt == '0)   state_next = GAP;
      GAP:     if (cnt == '0)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    sync_en = (state == HOLD);
    busy    = (state != IDLE);
  end

  // The captured word persists after the transfer until the next grant or reset.
  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      cnt       <= '0;
      rr_ptr    <= '0;
      gnt       <= '0;
      grant_id  <= '0;
      sync_data <= '0;
      done      <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_fire) begin
            sync_data <= win_word;
            gnt       <= win_onehot;
            grant_id  <= win_idx;
            rr_ptr    <= rr_next;
            cnt       <= CNT_W'(HOLD_CYCLES - 1);
          end
        end
        HOLD: begin
          if (cnt == '0) cnt <= CNT_W'(GAP_CYCLES - 1);
          else           cnt <= cnt - CNT_W'(1);
        end
        GAP: begin
          if (cnt == '0) done <= 1'b1;
          else           cnt  <= cnt - CNT_W'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
